// File: rtl/sequenciador_tipo_r.sv
// sequenciador_tipo_r: multi-cycle sequencer for MIPS R-type instructions.
// It accepts one instruction per valid/ready handshake, then drives the
// register-file read ports, the ALU operation code and the register-file
// write port through READ -> EXEC -> WRITE -> DONE. Unsupported opcodes or
// functs are rejected and complete immediately with Done+Error.
module sequenciador_tipo_r #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   InstrValid,
    output logic                   InstrReady,
    input  logic [31:0]            Instr,
    output logic [4:0]             ReadRegister1,
    output logic [4:0]             ReadRegister2,
    input  logic [31:0]            ReadData1,
    input  logic [31:0]            ReadData2,
    output logic [3:0]             ALUOperation,
    input  logic [31:0]            ALUResult,
    input  logic                   Zero,
    output logic                   RegWrite,
    output logic [4:0]             WriteRegister,
    output logic [31:0]            WriteData,
    output logic                   Done,
    output logic                   Error,
    output logic [31:0]            Result,
    output logic                   ResultZero,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

    state_t                  state, stateNext;
    logic [4:0]              rdReg, rdNext;
    logic                    readyNext, regWriteNext, doneNext, errorNext, resultZeroNext;
    logic [4:0]              readReg1Next, readReg2Next, writeRegNext;
    logic [3:0]              aluOpNext;
    logic [31:0]             writeDataNext, resultNext;
    logic [COUNT_WIDTH-1:0]  countNext;
    logic [4:0]              decoded;

    // The sequencer never inspects shamt or the operand data; the ALU consumes the operands.
    logic unusedBits;
    assign unusedBits = ^{Instr[10:6], ReadData1, ReadData2};

    // Maps funct to {supported, ALU control code}.
    function automatic logic [4:0] decodeFunct(input logic [5:0] funct);
        logic [4:0] r;
        r = 5'b0_0000;
        case (funct)
            6'b100000: r = 5'b1_0010;  // add
            6'b100010: r = 5'b1_0110;  // sub
            6'b100100: r = 5'b1_0000;  // and
            6'b100101: r = 5'b1_0001;  // or
            6'b101010: r = 5'b1_0111;  // slt
            6'b100111: r = 5'b1_1100;  // nor
            default:   r = 5'b0_0000;
        endcase
        return r;
    endfunction

    assign decoded = decodeFunct(Instr[5:0]);

    // State and every output are registered; async reset discards any pending instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rdReg         <= '0;
            InstrReady    <= 1'b0;
            ReadRegister1 <= '0;
            ReadRegister2 <= '0;
            ALUOperation  <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            Done          <= 1'b0;
            Error         <= 1'b0;
            Result        <= '0;
            ResultZero    <= 1'b0;
            InstrCount    <= '0;
        end else begin
            state         <= stateNext;
            rdReg         <= rdNext;
            InstrReady    <= readyNext;
            ReadRegister1 <= readReg1Next;
            ReadRegister2 <= readReg2Next;
            ALUOperation  <= aluOpNext;
            RegWrite      <= regWriteNext;
            WriteRegister <= writeRegNext;
            WriteData     <= writeDataNext;
            Done          <= doneNext;
            Error         <= errorNext;
            Result        <= resultNext;
            ResultZero    <= resultZeroNext;
            InstrCount    <= countNext;
        end
    end

    // Next-state and next-output logic; pulses default low, held values default to themselves.
    always_comb begin
        stateNext      = state;
        rdNext         = rdReg;
        readyNext      = 1'b0;
        readReg1Next   = ReadRegister1;
        readReg2Next   = ReadRegister2;
        aluOpNext      = ALUOperation;
        regWriteNext   = 1'b0;
        writeRegNext   = '0;
        writeDataNext  = '0;
        doneNext       = 1'b0;
        errorNext      = 1'b0;
        resultNext     = Result;
        resultZeroNext = ResultZero;
        countNext      = InstrCount;
        case (state)
            IDLE: begin
                readyNext = 1'b1;
                if (InstrValid && InstrReady) begin
                    readyNext = 1'b0;
                    if (Instr[31:26] == 6'd0 && decoded[4]) begin
                        stateNext    = READ;
                        readReg1Next = Instr[25:21];
                        readReg2Next = Instr[20:16];
                        aluOpNext    = decoded[3:0];
                        rdNext       = Instr[15:11];
                    end else begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        errorNext = 1'b1;
                    end
                end
            end
            READ: stateNext = EXEC;
            EXEC: begin
                // ALU output is settled by now; the write-back values come straight from it.
                stateNext      = WRITE;
                resultNext     = ALUResult;
                resultZeroNext = Zero;
                writeRegNext   = rdReg;
                writeDataNext  = ALUResult;
                regWriteNext   = (rdReg != 5'd0);
            end
            WRITE: begin
                stateNext = DONE;
                doneNext  = 1'b1;
                countNext = InstrCount + COUNT_WIDTH'(1);
            end
            DONE: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/sequenciador_tipo_r.md
# sequenciador_tipo_r

Multi-cycle R-type instruction sequencer that drives the register file and ALU from the control side. It accepts one 32-bit MIPS R-type instruction per valid/ready handshake and decodes rs/rt/rd/funct. It steps the register-file read ports, ALU operation code and register-file write port through a fixed four-state schedule, then reports the result. It sits between an instruction source (fetch stage or bench) and the existing `Registradores`/`ALU` pair, replacing hand-driven stimulus of those ports.

## Interface
- COUNT_WIDTH, 16, width of the completed-instruction counter
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- InstrValid  in  1  instruction source has Instr available
- InstrReady  out  1  sequencer can accept an instruction
- Instr  in  32  R-type instruction word, sampled on handshake
- ReadRegister1  out  5  register-file read address 1 (rs)
- ReadRegister2  out  5  register-file read address 2 (rt)
- ReadData1  in  32  register-file read data 1 (combinational from ReadRegister1)
- ReadData2  in  32  register-file read data 2 (combinational from ReadRegister2)
- ALUOperation  out  4  ALU control code
- ALUResult  in  32  ALU result (combinational)
- Zero  in  1  ALU zero flag
- RegWrite  out  1  register-file write enable
- WriteRegister  out  5  register-file write address (rd)
- WriteData  out  32  register-file write data
- Done  out  1  one-cycle completion pulse
- Error  out  1  qualifies Done: instruction rejected
- Result  out  32  last ALU result, held until next Done
- ResultZero  out  1  last Zero flag, held until next Done
- InstrCount  out  COUNT_WIDTH  successfully executed instructions, wraps

## Operation
- All outputs registered. Reset values: InstrReady 0; RegWrite, Done, Error 0; all address, data, ALUOperation, Result, ResultZero, InstrCount 0; state IDLE.
- States: IDLE → READ → EXEC → WRITE → DONE → IDLE; error path IDLE → DONE.
- IDLE: InstrReady=1. Handshake = InstrValid & InstrReady at a rising edge. On handshake, latch Instr and drop InstrReady.
  - Valid when opcode[31:26]=0 and funct is supported: go to READ.
  - Otherwise: go to DONE with Error set.
- Funct → ALUOperation mapping:
  - 100000 add → 0010
  - 100010 sub → 0110
  - 100100 and → 0000
  - 100101 or → 0001
  - 101010 slt → 0111
  - 100111 nor → 1100
  - Any other funct is an error. shamt is ignored.
- READ: ReadRegister1=rs, ReadRegister2=rt; ALUOperation set to mapped code. Both held through WRITE.
- EXEC: at end of cycle, capture ALUResult → Result and Zero → ResultZero.
- WRITE: WriteRegister=rd, WriteData=Result for exactly this cycle. RegWrite=1 unless rd=0; rd=0 suppresses the write but still completes normally.
- DONE: Done=1 for one cycle and RegWrite=0.
  - Normal path: Error=0; InstrCount increments by 1, modulo 2^COUNT_WIDTH (all-ones → 0).
  - Error path: Error=1; no read, write or count change; Result/ResultZero keep previous values.
- Return to IDLE after DONE; InstrReady=1 in the cycle following Done.
- Error is only meaningful while Done=1; it is 0 otherwise.

## Timing
- Handshake at edge N:
  - READ occupies cycle N+1.
  - EXEC occupies cycle N+2.
  - WRITE occupies cycle N+3 (RegWrite high).
  - DONE occupies cycle N+4 (Done high).
  - InstrReady returns at N+5.
- Throughput: one instruction per 5 cycles; error path takes 2 cycles from handshake to InstrReady.
- InstrReady rises at the first rising edge after rst_n deasserts.
- InstrValid while InstrReady=0 is ignored; the source must hold Instr until the handshake.
- WriteRegister/WriteData stable for the entire cycle RegWrite is high, so either a latch-style or edge-triggered register file captures correctly.
- rst_n asserted mid-instruction: outputs go to reset values immediately (asynchronously). The pending instruction is discarded, no further RegWrite or Done is produced, and InstrCount clears.

## Test plan
- Bench register-file model preloaded $1=10, $2=20.
- Add: Instr 0x00221820 (add $3,$1,$2) → RegWrite pulse 3 cycles after handshake with WriteRegister=3, WriteData=30; Done next cycle, Error=0, Result=30, ResultZero=0, InstrCount=1.
- Sub, negative and zero results:
  - 0x00222022 (sub $4,$1,$2) → WriteData=0xFFFFFFF6, ResultZero=0.
  - Then 0x00212822 (sub $5,$1,$1) → WriteData=0, ResultZero=1.
- And with zero result, then rd=0:
  - 0x00223024 (and $6,$1,$2) → Result=0, ResultZero=1.
  - Then 0x00220020 (add $0,$1,$2) → RegWrite stays 0, Done with Result=30, InstrCount increments.
- Rejected instructions:
  - 0x8C220000 (lw opcode) → Done+Error 1 cycle after handshake, no RegWrite, InstrCount and Result unchanged.
  - Same for funct 000000 (0x00221800).
- Handshake and reset:
  - InstrValid held high continuously → handshakes exactly every 5 cycles.
  - rst_n pulled low during WRITE → RegWrite drops immediately, no Done, InstrCount=0, InstrReady high one edge after release.
- Counter wrap: COUNT_WIDTH=4, 17 valid adds → InstrCount reads 15 after 15th, 0 after 16th, 1 after 17th.
